perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
Parametrised event-counter bank replacing the fixed-function performance monitor attached to the 5-stage RV32I core. Counts a configurable number of single-bit pipeline events (retire, stall, bubble, flush, hazard, forward, branch, …) plus a cycle counter. Detects program completion from the IF-stage instruction and PC streams. Provides an atomic snapshot bank with a registered read port for the testbench or a future CSR interface.

Parameters:
NUM_EVENTS, 9, number of event inputs and event counters
CNT_W, 32, width of each event counter and the cycle counter
FINISH_THRESH, 10, consecutive qualifying cycles that declare program finished (legal 1..255)
ADDR_W, $clog2(NUM_EVENTS+1), read-address width (derived; do not override)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
perf_enable  in  1  counting enable
event_vec  in  NUM_EVENTS  per-cycle event strobes; bit i increments counter i
instr_if  in  32  IF-stage instruction word
pc_if  in  32  IF-stage PC
clear  in  1  zero all live counters and overflow flags; return to IDLE
snap_req  in  1  copy live counters into the shadow bank
snap_valid  out  1  one-cycle pulse, cycle after snap_req
rd_addr  in  ADDR_W  shadow-bank index; NUM_EVENTS selects the cycle counter
rd_data  out  CNT_W  registered shadow read
ovf  out  NUM_EVENTS+1  sticky overflow flags; MSB is the cycle counter
finished  out  1  level, high in DONE
finish_pulse  out  1  one-cycle pulse on entry to DONE
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (sync, any cycle, including mid-snapshot): all counters, shadows, streaks, ovf, rd_data, snap_valid, finished and finish_pulse go to 0; state becomes IDLE.
- FSM states:
  - IDLE=0: counters hold. Goes to RUN when perf_enable=1.
  - RUN=1: counting. Goes to IDLE when perf_enable=0. Goes to DONE on finish detect.
  - DONE=2: counters frozen. Goes to IDLE only on clear.
  - 3: unused; recovers to IDLE.
- Counting (RUN only):
  - cycle_cnt increments by 1 every cycle.
  - cnt[i] increments by 1 when event_vec[i]=1.
  - The cycle that causes RUN→DONE is still counted.
- Overflow: an increment from all-ones wraps to 0 and sets the matching ovf bit. The bit stays set until clear or rst.
- Finish detect (RUN only):
  - zero_streak increments when instr_if==0, else resets to 0.
  - pc_streak increments when pc_if equals the previous-cycle pc_if, else resets to 0.
  - Both streaks saturate at FINISH_THRESH.
  - Transition to DONE happens on the edge where either streak reaches FINISH_THRESH. finished is high from the next cycle, so FINISH_THRESH qualifying cycles produce finished on cycle FINISH_THRESH+1.
  - Streaks clear on leaving RUN.
  - The pc_if history register updates every cycle regardless of state.
- Snapshot:
  - On snap_req, all shadows take the pre-edge live values, i.e. excluding this cycle's increments.
  - snap_valid pulses on the next cycle.
  - Back-to-back requests are legal; each produces its own pulse.
- Read: rd_data <= shadow[rd_addr] with 1-cycle latency. Addresses above NUM_EVENTS return 0. The read path is independent of FSM state.
- Simultaneous events:
  - clear and snap_req together: the snapshot captures the pre-clear values, then live counters zero.
  - clear and a finish condition together: clear wins and the state goes to IDLE.
  - rst overrides everything.
- No combinational path from any input to any output.

Optional Feature:
PERF_SATURATE_EN
- Defined: counters saturate at all-ones instead of wrapping. The ovf bit is still set on the first blocked increment.
- Undefined: modulo-2^CNT_W wrap as above.

Decomposition:
- Package perf_pkg:
  - state enum (PERF_IDLE, PERF_RUN, PERF_DONE)
  - event index constants (EV_RETIRE=0, EV_STALL=1, EV_BUBBLE=2, EV_FLUSH=3, EV_RAW=4, EV_FWD1=5, EV_FWD2=6, EV_CBR=7, EV_UBR=8)
  - default FINISH_THRESH
- Sub-module perf_finish_detect: both streak counters, the pc history register and the finish strobe. Parameters: FINISH_THRESH.

Test Plan:
1. rst; perf_enable=1; event_vec=9'h001 for 20 cycles; snap_req; read addr 0 and addr 9 → rd_data=20, then 20 (cycle counter); snap_valid one pulse.
2. RUN; instr_if=0 held 10 cycles with pc_if changing → finish_pulse once, finished=1. Further event strobes leave counters unchanged. clear → state_o=0, all reads 0 after a new snapshot.
3. pc_if constant 9 cycles, then changes, then constant 10 cycles → no finish after the first run; finish after the second.
4. CNT_W=4; event_vec[2] high 17 cycles → without macro cnt[2]=1 and ovf[2]=1; with PERF_SATURATE_EN cnt[2]=15 and ovf[2]=1.
5. clear and snap_req in the same cycle after 5 events on bit 1 → shadow[1]=5 and live counter=0; a second snapshot after 3 more events reads 3.
6. Assert rst mid-RUN with counters at 7 → all outputs 0 on the next cycle; rd_addr=10 with NUM_EVENTS=9 → rd_data=0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_pkg;

    typedef enum logic [1:0] {
        PERF_IDLE = 2'd0,
        PERF_RUN  = 2'd1,
        PERF_DONE = 2'd2
    } perf_state_e;

    localparam int EV_RETIRE = 0;
    localparam int EV_STALL  = 1;
    localparam int EV_BUBBLE = 2;
    localparam int EV_FLUSH  = 3;
    localparam int EV_RAW    = 4;
    localparam int EV_FWD1   = 5;
    localparam int EV_FWD2   = 6;
    localparam int EV_CBR    = 7;
    localparam int EV_UBR    = 8;

    localparam int PERF_FINISH_THRESH_DEF = 10;

endpackage

// File: rtl/perf_finish_detect.sv
// Program-completion detector: zero-instruction and stuck-PC streaks.
module perf_finish_detect #(
    parameter int FINISH_THRESH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        finish_o
);

    localparam logic [7:0] THR = 8'(FINISH_THRESH);

    logic [7:0]  zero_q, zero_d;
    logic [7:0]  pcs_q, pcs_d;
    logic [31:0] pc_prev_q;

    always_comb begin
        zero_d = 8'd0;
        pcs_d  = 8'd0;
        if (instr_i == 32'd0) begin
            zero_d = (zero_q == THR) ? THR : zero_q + 8'd1;
        end
        if (pc_i == pc_prev_q) begin
            pcs_d = (pcs_q == THR) ? THR : pcs_q + 8'd1;
        end
    end

    // Strobe on the edge where either streak reaches the threshold.
    assign finish_o = run_i && ((zero_d == THR) || (pcs_d == THR));

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q    <= 8'd0;
            pcs_q     <= 8'd0;
            pc_prev_q <= 32'd0;
        end else begin
            pc_prev_q <= pc_i;
            zero_q    <= run_i ? zero_d : 8'd0;
            pcs_q     <= run_i ? pcs_d : 8'd0;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Event counter bank with cycle counter, finish FSM and snapshot bank.
// Define PERF_SATURATE_EN to saturate counters instead of wrapping.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS    = 9,
    parameter int CNT_W         = 32,
    parameter int FINISH_THRESH = PERF_FINISH_THRESH_DEF,
    parameter int ADDR_W        = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  perf_enable,
    input  logic [NUM_EVENTS-1:0] event_vec,
    input  logic [31:0]           instr_if,
    input  logic [31:0]           pc_if,
    input  logic                  clear,
    input  logic                  snap_req,
    output logic                  snap_valid,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [CNT_W-1:0]      rd_data,
    output logic [NUM_EVENTS:0]   ovf,
    output logic                  finished,
    output logic                  finish_pulse,
    output logic [1:0]            state_o
);

    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_EVENTS);

    perf_state_e state_q, state_d;
    logic        finished_q, finish_pulse_q;
    logic        run, finish;

    logic [CNT_W-1:0]    cnt_q    [NUM_EVENTS+1];
    logic [CNT_W-1:0]    cnt_d    [NUM_EVENTS+1];
    logic [CNT_W-1:0]    shadow_q [NUM_EVENTS+1];
    logic [NUM_EVENTS:0] ovf_q, ovf_d, inc;
    logic                snap_valid_q;
    logic [CNT_W-1:0]    rd_data_q;

    assign run = (state_q == PERF_RUN);

    perf_finish_detect #(
        .FINISH_THRESH(FINISH_THRESH)
    ) u_finish (
        .clk     (clk),
        .rst     (rst),
        .run_i   (run),
        .instr_i (instr_if),
        .pc_i    (pc_if),
        .finish_o(finish)
    );

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = PERF_IDLE;
        end else begin
            unique case (state_q)
                PERF_IDLE: if (perf_enable) state_d = PERF_RUN;
                PERF_RUN: begin
                    if (finish)            state_d = PERF_DONE;
                    else if (!perf_enable) state_d = PERF_IDLE;
                end
                PERF_DONE: state_d = PERF_DONE;
                default:   state_d = PERF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= PERF_IDLE;
            finished_q     <= 1'b0;
            finish_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            finished_q     <= (state_d == PERF_DONE);
            finish_pulse_q <= run && (state_d == PERF_DONE);
        end
    end

    // Top slot is the cycle counter, always incremented while running.
    assign inc = {1'b1, event_vec} & {(NUM_EVENTS + 1){run}};

    always_comb begin
        for (int i = 0; i <= NUM_EVENTS; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clear) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (inc[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
`ifdef PERF_SATURATE_EN
                    cnt_d[i] = cnt_q[i];
`else
                    cnt_d[i] = '0;
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_EVENTS; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            ovf_q        <= '0;
            snap_valid_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            for (int i = 0; i <= NUM_EVENTS; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (snap_req) shadow_q[i] <= cnt_q[i];
            end
            ovf_q        <= ovf_d;
            snap_valid_q <= snap_req;
            rd_data_q    <= (rd_addr > LAST_ADDR) ? '0 : shadow_q[rd_addr];
        end
    end

    assign snap_valid   = snap_valid_q;
    assign rd_data      = rd_data_q;
    assign ovf          = ovf_q;
    assign finished     = finished_q;
    assign finish_pulse = finish_pulse_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank (32-bit and 4-bit instances).
module tb_perf_counter_bank;

    localparam int N  = 9;
    localparam int T  = 10;
    localparam int AW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst, perf_enable, clear, snap_req;
    logic [N-1:0]  event_vec;
    logic [31:0]   instr_if, pc_if;
    logic [AW-1:0] rd_addr;

    logic          snap_valid, finished, finish_pulse;
    logic [1:0]    state_o;
    logic [31:0]   rd_data;
    logic [N:0]    ovf;
    logic          sv_s, fin_s, fp_s;
    logic [1:0]    st_s;
    logic [3:0]    rd_s;
    logic [N:0]    ovf_s;

    int checks   = 0;
    int failures = 0;

    // Model keeps unbounded event totals; width effects are derived later.
    longint      m_n  [0:N];
    longint      m_sh [0:N];
    longint      m_rd;
    int          m_state, m_z, m_p;
    bit          m_fin, m_pulse, m_sv;
    logic [31:0] m_pcprev;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_EVENTS(N), .CNT_W(32), .FINISH_THRESH(T)) u_dut (
        .clk(clk), .rst(rst), .perf_enable(perf_enable),
        .event_vec(event_vec), .instr_if(instr_if), .pc_if(pc_if),
        .clear(clear), .snap_req(snap_req), .snap_valid(snap_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .ovf(ovf),
        .finished(finished), .finish_pulse(finish_pulse), .state_o(state_o)
    );

    perf_counter_bank #(.NUM_EVENTS(N), .CNT_W(4), .FINISH_THRESH(T)) u_small (
        .clk(clk), .rst(rst), .perf_enable(perf_enable),
        .event_vec(event_vec), .instr_if(instr_if), .pc_if(pc_if),
        .clear(clear), .snap_req(snap_req), .snap_valid(sv_s),
        .rd_addr(rd_addr), .rd_data(rd_s), .ovf(ovf_s),
        .finished(fin_s), .finish_pulse(fp_s), .state_o(st_s)
    );

    function automatic longint ev(longint n, int w);
        longint lim = longint'(1) << w;
`ifdef PERF_SATURATE_EN
        return (n >= lim) ? lim - 1 : n;
`else
        return n % lim;
`endif
    endfunction

    function automatic logic [N:0] eovf(int w);
        logic [N:0] v;
        for (int i = 0; i <= N; i++) v[i] = (m_n[i] >= (longint'(1) << w));
        return v;
    endfunction

    task automatic model_edge();
        bit run, fin;
        run = (m_state == 1);
        if (rst) begin
            for (int i = 0; i <= N; i++) begin m_n[i] = 0; m_sh[i] = 0; end
            m_rd = 0; m_sv = 0; m_state = 0; m_z = 0; m_p = 0;
            m_fin = 0; m_pulse = 0; m_pcprev = 32'd0;
            return;
        end
        m_rd = 0;
        if (int'(rd_addr) <= N) m_rd = m_sh[rd_addr];
        m_sv = snap_req;
        if (snap_req) m_sh = m_n;
        fin = 0;
        if (run) begin
            m_z = (instr_if == 32'd0) ? ((m_z < T) ? m_z + 1 : T) : 0;
            m_p = (pc_if == m_pcprev) ? ((m_p < T) ? m_p + 1 : T) : 0;
            fin = (m_z == T) || (m_p == T);
        end else begin
            m_z = 0; m_p = 0;
        end
        m_pcprev = pc_if;
        if (clear) begin
            for (int i = 0; i <= N; i++) m_n[i] = 0;
        end else if (run) begin
            m_n[N]++;
            for (int i = 0; i < N; i++) if (event_vec[i]) m_n[i]++;
        end
        m_pulse = 0;
        if (clear) m_state = 0;
        else if (m_state == 0) begin
            if (perf_enable) m_state = 1;
        end else if (m_state == 1) begin
            if (fin) begin m_state = 2; m_pulse = 1; end
            else if (!perf_enable) m_state = 0;
        end
        m_fin = (m_state == 2);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic fetch();
        pc_if    = pc_if + 32'd4;
        instr_if = $urandom | 32'd1;
    endtask

    task automatic test_reset();
        rst = 1; perf_enable = 0; clear = 0; snap_req = 0;
        event_vec = '0; instr_if = 32'd1; pc_if = 32'h100; rd_addr = '0;
        step(); step();
        rst = 0;
        checks++;
        if (state_o !== 2'd0 || st_s !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d/%0d exp=0", state_o, st_s);
        end
        checks++;
        if ({finished, finish_pulse, snap_valid, fin_s, fp_s, sv_s} !== 6'd0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0",
                     {finished, finish_pulse, snap_valid, fin_s, fp_s, sv_s});
        end
        checks++;
        if (rd_data !== 32'd0 || rd_s !== 4'd0 || ovf !== '0 || ovf_s !== '0) begin
            failures++;
            $display("FAIL reset_data rd=%0d/%0d ovf=%h/%h exp=0", rd_data, rd_s, ovf, ovf_s);
        end
    endtask

    task automatic test_count();
        perf_enable = 1; fetch(); step();
        checks++;
        if (state_o !== 2'(m_state) || m_state != 1) begin
            failures++;
            $display("FAIL enter_run got=%0d exp=%0d", state_o, m_state);
        end
        event_vec = 9'h001;
        repeat (20) begin fetch(); step(); end
        event_vec = '0; snap_req = 1; fetch(); step();
        snap_req = 0;
        checks++;
        if (snap_valid !== 1'b1 || sv_s !== 1'b1) begin
            failures++;
            $display("FAIL snap_pulse got=%b/%b exp=1", snap_valid, sv_s);
        end
        rd_addr = 4'd0; fetch(); step();
        checks++;
        if (snap_valid !== 1'b0) begin
            failures++;
            $display("FAIL snap_pulse_end got=%b exp=0", snap_valid);
        end
        checks++;
        if (rd_data !== 32'd20 || rd_data !== 32'(ev(m_rd, 32))) begin
            failures++;
            $display("FAIL retire_cnt got=%0d exp=20", rd_data);
        end
        rd_addr = 4'd9; fetch(); step();
        checks++;
        if (rd_data !== 32'd20 || rd_s !== 4'(ev(m_rd, 4))) begin
            failures++;
            $display("FAIL cycle_cnt got=%0d/%0d exp=20/%0d", rd_data, rd_s, ev(m_rd, 4));
        end
    endtask

    task automatic test_random();
        repeat (200) begin
            event_vec   = N'($urandom);
            snap_req    = ($urandom_range(0, 5) == 0);
            perf_enable = ($urandom_range(0, 15) != 0);
            rd_addr     = AW'($urandom_range(0, 11));
            fetch(); step();
            checks++;
            if (rd_data !== 32'(ev(m_rd, 32)) || rd_s !== 4'(ev(m_rd, 4))) begin
                failures++;
                $display("FAIL rand_rd got=%0d/%0d exp=%0d/%0d",
                         rd_data, rd_s, ev(m_rd, 32), ev(m_rd, 4));
            end
            checks++;
            if (snap_valid !== m_sv || state_o !== 2'(m_state) || ovf_s !== eovf(4)) begin
                failures++;
                $display("FAIL rand_ctrl sv=%b st=%0d ovf=%h exp=%b %0d %h",
                         snap_valid, state_o, ovf_s, m_sv, m_state, eovf(4));
            end
        end
        snap_req = 0; perf_enable = 1; event_vec = '0; fetch(); step();
    endtask

    task automatic test_finish_zero();
        for (int k = 1; k <= T; k++) begin
            instr_if = 32'd0; pc_if = pc_if + 32'd4; step();
            checks++;
            if (finished !== m_fin || finish_pulse !== m_pulse) begin
                failures++;
                $display("FAIL zero_streak k=%0d got=%b%b exp=%b%b",
                         k, finished, finish_pulse, m_fin, m_pulse);
            end
        end
        checks++;
        if (finished !== 1'b1 || finish_pulse !== 1'b1 || state_o !== 2'd2) begin
            failures++;
            $display("FAIL zero_done got=%b%b st=%0d exp=11 st=2", finished, finish_pulse, state_o);
        end
        repeat (5) begin event_vec = N'($urandom); fetch(); step(); end
        event_vec = '0;
        checks++;
        if (finish_pulse !== 1'b0 || finished !== 1'b1) begin
            failures++;
            $display("FAIL done_hold got=%b%b exp=10", finished, finish_pulse);
        end
        snap_req = 1; fetch(); step(); snap_req = 0;
        for (int a = 0; a <= N; a++) begin
            rd_addr = AW'(a); fetch(); step();
            checks++;
            if (rd_data !== 32'(ev(m_rd, 32))) begin
                failures++;
                $display("FAIL frozen a=%0d got=%0d exp=%0d", a, rd_data, ev(m_rd, 32));
            end
        end
        perf_enable = 0; clear = 1; fetch(); step(); clear = 0;
        checks++;
        if (state_o !== 2'd0 || finished !== 1'b0) begin
            failures++;
            $display("FAIL clear_idle got st=%0d fin=%b exp=0", state_o, finished);
        end
        snap_req = 1; fetch(); step(); snap_req = 0;
        for (int a = 0; a <= N; a++) begin
            rd_addr = AW'(a); fetch(); step();
            checks++;
            if (rd_data !== 32'd0 || rd_data !== 32'(ev(m_rd, 32))) begin
                failures++;
                $display("FAIL cleared a=%0d got=%0d exp=0", a, rd_data);
            end
        end
    endtask

    task automatic test_finish_pc();
        perf_enable = 1; instr_if = 32'h13; pc_if = 32'h2000; step();
        repeat (9) begin instr_if = $urandom | 32'd1; step(); end
        checks++;
        if (finished !== 1'b0 || state_o !== 2'd1 || finished !== m_fin) begin
            failures++;
            $display("FAIL pc_nine got fin=%b st=%0d exp=0 st=1", finished, state_o);
        end
        pc_if = 32'h3000; step();
        for (int k = 1; k <= T; k++) begin
            instr_if = $urandom | 32'd1; step();
            checks++;
            if (finished !== m_fin || finish_pulse !== m_pulse || fp_s !== m_pulse) begin
                failures++;
                $display("FAIL pc_streak k=%0d got=%b%b exp=%b%b",
                         k, finished, finish_pulse, m_fin, m_pulse);
            end
        end
        checks++;
        if (finished !== 1'b1 || state_o !== 2'd2) begin
            failures++;
            $display("FAIL pc_done got fin=%b st=%0d exp=1 st=2", finished, state_o);
        end
        perf_enable = 0; clear = 1; fetch(); step(); clear = 0;
    endtask

    task automatic test_overflow();
        perf_enable = 1; fetch(); step();
        event_vec = 9'h004;
        repeat (17) begin fetch(); step(); end
        event_vec = '0; snap_req = 1; fetch(); step(); snap_req = 0;
        rd_addr = 4'd2; fetch(); step();
        checks++;
`ifdef PERF_SATURATE_EN
        if (rd_s !== 4'd15 || rd_s !== 4'(ev(m_rd, 4))) begin
            failures++;
            $display("FAIL small_cnt got=%0d exp=15", rd_s);
        end
`else
        if (rd_s !== 4'd1 || rd_s !== 4'(ev(m_rd, 4))) begin
            failures++;
            $display("FAIL small_cnt got=%0d exp=1", rd_s);
        end
`endif
        checks++;
        if (ovf_s[2] !== 1'b1 || ovf_s !== eovf(4) || ovf !== eovf(32)) begin
            failures++;
            $display("FAIL ovf got=%h/%h exp=%h/%h", ovf_s, ovf, eovf(4), eovf(32));
        end
        checks++;
        if (rd_data !== 32'd17) begin
            failures++;
            $display("FAIL wide_cnt got=%0d exp=17", rd_data);
        end
    endtask

    task automatic test_clear_snap();
        perf_enable = 1; clear = 1; fetch(); step(); clear = 0;
        fetch(); step();
        event_vec = 9'h002;
        repeat (5) begin fetch(); step(); end
        event_vec = '0; clear = 1; snap_req = 1; fetch(); step();
        clear = 0; rd_addr = 4'd1; fetch(); step();
        snap_req = 0;
        checks++;
        if (rd_data !== 32'd5 || rd_data !== 32'(ev(m_rd, 32))) begin
            failures++;
            $display("FAIL preclear_snap got=%0d exp=5", rd_data);
        end
        fetch(); step();
        checks++;
        if (rd_data !== 32'd0 || rd_data !== 32'(ev(m_rd, 32))) begin
            failures++;
            $display("FAIL postclear_live got=%0d exp=0", rd_data);
        end
        event_vec = 9'h002;
        repeat (3) begin fetch(); step(); end
        event_vec = '0; snap_req = 1; fetch(); step(); snap_req = 0;
        fetch(); step();
        checks++;
        if (rd_data !== 32'd3 || rd_data !== 32'(ev(m_rd, 32))) begin
            failures++;
            $display("FAIL second_snap got=%0d exp=3", rd_data);
        end
    endtask

    task automatic test_reset_mid();
        perf_enable = 1; clear = 1; fetch(); step(); clear = 0;
        fetch(); step();
        event_vec = '1;
        repeat (7) begin fetch(); step(); end
        event_vec = '0; snap_req = 1; fetch(); step();
        rd_addr = 4'd3; fetch(); step();
        checks++;
        if (rd_data !== 32'd7) begin
            failures++;
            $display("FAIL pre_rst_cnt got=%0d exp=7", rd_data);
        end
        rst = 1; fetch(); step(); rst = 0; snap_req = 0;
        checks++;
        if ({snap_valid, finished, finish_pulse, state_o} !== 5'd0 ||
            rd_data !== 32'd0 || ovf !== '0 || ovf_s !== '0) begin
            failures++;
            $display("FAIL mid_rst sv=%b fin=%b fp=%b st=%0d rd=%0d exp=0",
                     snap_valid, finished, finish_pulse, state_o, rd_data);
        end
        fetch(); step(); event_vec = 9'h1ff;
        repeat (4) begin fetch(); step(); end
        event_vec = '0; snap_req = 1; fetch(); step(); snap_req = 0;
        rd_addr = 4'd10; fetch(); step();
        checks++;
        if (rd_data !== 32'd0 || rd_s !== 4'd0) begin
            failures++;
            $display("FAIL addr_oob got=%0d/%0d exp=0", rd_data, rd_s);
        end
        rd_addr = 4'd9; fetch(); step();
        checks++;
        if (rd_data !== 32'(ev(m_rd, 32)) || rd_data !== 32'd4) begin
            failures++;
            $display("FAIL post_rst_cycle got=%0d exp=4", rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_random();
        test_finish_zero();
        test_finish_pc();
        test_overflow();
        test_clear_snap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
